// File: rtl/tmc_stream_mem_loader.sv
// Byte-stream to 32-bit word writer for the program/data RAM slave port.
// Packs bytes little-endian, writes consecutive word addresses with wrap at DEPTH,
// and reports completion (or command rejection) with a one-cycle done pulse.
module tmc_stream_mem_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 9000,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [1:0]          lane_q;
  logic [31:0]         data_q;
  logic [3:0]          be_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                s_ready_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic                mem_wr_q;

  logic                accept_c;
  logic                last_byte_c;
  logic [31:0]         data_d;
  logic [3:0]          be_d;
  logic [LEN_W-1:0]    rem_d;
  logic [ADDR_W-1:0]   addr_d;

  // Byte merge, remaining-count decrement and wrapped next word address.
  always_comb begin
    accept_c    = (state_q == S_FILL) && s_valid && s_ready_q;
    last_byte_c = (lane_q == 2'd3) || (rem_q == LEN_W'(1));
    data_d      = data_q;
    data_d[{lane_q, 3'b000} +: 8] = s_data;
    be_d        = be_q;
    be_d[lane_q] = 1'b1;
    rem_d       = rem_q - LEN_W'(1);
    addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      lane_q        <= '0;
      data_q        <= '0;
      be_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      s_ready_q     <= 1'b0;
      mem_address_q <= '0;
      mem_wr_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            if (32'(cmd_base) >= DEPTH) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (cmd_len == LEN_W'(0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              addr_q    <= cmd_base;
              rem_q     <= cmd_len;
              lane_q    <= '0;
              be_q      <= '0;
              data_q    <= '0;
              busy_q    <= 1'b1;
              s_ready_q <= 1'b1;
              state_q   <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (accept_c) begin
            data_q <= data_d;
            be_q   <= be_d;
            lane_q <= lane_q + 2'd1;
            rem_q  <= rem_d;
            if (last_byte_c) begin
              s_ready_q     <= 1'b0;
              mem_wr_q      <= 1'b1;
              mem_address_q <= addr_q;
              state_q       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (rem_q == LEN_W'(0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end else begin
            addr_q    <= addr_d;
            lane_q    <= '0;
            be_q      <= '0;
            data_q    <= '0;
            s_ready_q <= 1'b1;
            state_q   <= S_FILL;
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign s_ready        = s_ready_q;
  assign mem_address    = mem_address_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = data_q;
  assign mem_chipselect = mem_wr_q;
  assign mem_write      = mem_wr_q;

endmodule

// File: doc/tmc_stream_mem_loader.md
# tmc_stream_mem_loader

Upstream feeder for the 9000 x 32-bit on-chip program/data RAM, driving its second Avalon slave port. Accepts a byte stream with valid/ready, packs bytes little-endian into 32-bit words, and issues single-cycle word writes with byte enables to consecutive word addresses. The address wraps at the RAM depth. One command (base word address, byte count) defines each transfer, and the block reports completion with a one-cycle done pulse.

## Interface
- ADDR_W, 14, word-address width; matches the RAM address port.
- DEPTH, 9000, RAM depth in 32-bit words; sets the wrap point and base-address range.
- LEN_W, 16, width of the byte-count field.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_start  in  1  one-cycle command strobe; sampled only in IDLE.
- cmd_base  in  ADDR_W  first word address of the transfer.
- cmd_len  in  LEN_W  transfer length in bytes.
- busy  out  1  high in FILL and WRITE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = command rejected, no writes issued.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  block accepts a byte this cycle.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  4  RAM byte enables; bit n covers writedata[8n+7:8n].
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  RAM write data.

## Operation
- The FSM has four states: IDLE, FILL, WRITE, DONE. State, address, lane counter, remaining count, data and byte-enable registers are all clocked.
- **IDLE:** s_ready=0, busy=0.
  - On cmd_start with cmd_base >= DEPTH, go to DONE with err=1.
  - On cmd_start with cmd_len==0, go to DONE with err=0. No writes are issued.
  - On any other cmd_start, latch addr=cmd_base, rem=cmd_len, lane=0, be=0, data=0, then go to FILL.
- **FILL:** s_ready=1.
  - On s_valid&s_ready: data[8*lane+:8]=s_data, be[lane]=1, lane+=1, rem-=1.
  - Go to WRITE when the accepted byte is in lane 3 or rem reaches 0.
- **WRITE:** s_ready=0. mem_chipselect=mem_write=1 for exactly this one cycle, with mem_address=addr, mem_writedata=data, mem_byteenable=be.
  - Lanes that were not filled carry data 0 and byteenable 0.
  - If rem==0, go to DONE.
  - Otherwise set addr = (addr==DEPTH-1) ? 0 : addr+1, clear lane/be/data, and go to FILL.
- **DONE:** done=1 for one cycle, err as decided above, then go to IDLE.
- cmd_start outside IDLE is ignored; there is no queuing.
- The RAM has no waitrequest, so every write is complete in its WRITE cycle.
- mem_address holds its last value outside WRITE. mem_chipselect and mem_write are 0 outside WRITE.

## Timing
- **Reset:** on the first edge with reset_n low, the state goes to IDLE. busy, done, err, s_ready, mem_chipselect, mem_write, mem_byteenable, mem_writedata and mem_address all become 0.
- Reset mid-transfer abandons the partial word, and no write occurs from that edge on.
- cmd_start at edge N puts the block in FILL at N+1, so s_ready is high at N+1.
- Throughput with s_valid held high is 4 bytes per 5 cycles (4 FILL cycles + 1 WRITE cycle). The final word is written the cycle after its last byte is accepted.
- done rises the cycle after the final WRITE, or the cycle after cmd_start for rejected or zero-length commands.
- A transfer of L>0 bytes takes ceil(L/4) writes. With s_valid always high, done asserts L + ceil(L/4) + 1 cycles after the cmd_start edge.
- s_valid low in FILL stalls the block with no state change. s_data is ignored while s_ready is 0.
- Wrap-around: after a write to DEPTH-1, the next write goes to 0. rem is never compared against DEPTH, so transfers longer than 4*DEPTH bytes overwrite earlier words.

## Test plan
- **Basic:** base=0x0010, len=8, bytes 01..08 with s_valid always high.
  - Writes 0x04030201 @0x0010 and 0x08070605 @0x0011, each with be=0xF.
  - done asserts 11 cycles after cmd_start, err=0.
- **Partial tail:** base=0x0100, len=6, bytes AA BB CC DD EE FF.
  - Writes 0xDDCCBBAA be=0xF @0x0100, then 0x0000FFEE be=0x3 @0x0101.
- **Wrap:** base=8999, len=8.
  - Writes go to 8999, then to 0.
  - No write to address 9000.
- **Errors and zero length:**
  - base=9000 gives done=1, err=1, and no mem_write.
  - len=0 gives done=1, err=0, and no mem_write.
  - A second cmd_start while busy is ignored, with no extra writes.
- **Backpressure:** s_valid toggling 1,0,0,1 on a len=5 transfer.
  - Byte order and data are preserved.
  - mem_write is high for exactly 2 cycles in total.
- **Reset mid-transfer:** reset_n low after 3 of 4 bytes are accepted.
  - No write is issued and all outputs are 0 the next cycle.
  - After release, a new len=4 command completes normally.
